// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: the data word, the FSM state
// encoding and the memory funct3 codes.
package Types;

    typedef logic [31:0] word;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR      = 3'd3,
        RESP    = 3'd4
    } lsu_state_t;

    // Loads and stores share encodings: LB/SB, LH/SH, LW/SW.
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } mem_funct3_t;

    // Byte and half stores need the old word first (read-modify-write).
    function automatic logic is_sub_word(input logic [2:0] funct3);
        return (funct3 == F3_B) || (funct3 == F3_H);
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational data alignment: extracts load results from a big-endian
// memory word and merges sub-word store data into the old word.
module lsu_align
    import Types::*;
(
    input  logic [2:0] funct3,
    input  logic       we,
    input  word        d,
    input  word        wdata,
    output word        load_data,
    output word        store_data
);

    // Load extraction: the addressed byte/half sits at the top of the word.
    always_comb begin
        load_data = d;
        case (funct3)
            F3_B:    load_data = {{24{d[31]}}, d[31:24]};
            F3_H:    load_data = {{16{d[31]}}, d[31:16]};
            F3_BU:   load_data = {24'd0, d[31:24]};
            F3_HU:   load_data = {16'd0, d[31:16]};
            default: load_data = d;
        endcase
    end

    // Store merge: replace the leading byte/half, keep the rest of the old word.
    always_comb begin
        store_data = d;
        if (we) begin
            case (funct3)
                F3_B:    store_data = {wdata[7:0], d[23:0]};
                F3_H:    store_data = {wdata[15:0], d[15:0]};
                default: store_data = wdata;
            endcase
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding request, registered memory port drive,
// read-modify-write for sub-word stores, one response per request.
//
// Handshakes: a request transfers on an edge where i_req_valid & o_req_ready;
// a response transfers on an edge where o_rsp_valid & i_rsp_ready. While a
// valid is high and its ready is low, the offering side holds its payload.
module load_store_unit
    import Types::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic       i_req_we,
    input  logic [2:0] i_req_funct3,
    input  word        i_req_addr,
    input  word        i_req_wdata,
    output logic       o_rsp_valid,
    input  logic       i_rsp_ready,
    output word        o_rsp_data,
    output word        o_r_mem_addr,
    input  word        i_r_mem_data,
    output word        o_w_mem_addr [0:1],
    output word        o_w_mem_data [0:1],
    output logic       o_w_mem_en   [0:1],
    output lsu_state_t o_state
);

    lsu_state_t state;
    logic       we_q;
    logic [2:0] funct3_q;
    word        addr_q;
    word        wdata_q;
    logic       rsp_valid_q;
    word        rsp_data_q;
    word        r_addr_q;
    logic       w_en_q;
    word        w_addr_q;
    word        w_data_q;
    word        load_data;
    word        store_data;

    lsu_align u_align (
        .funct3     (funct3_q),
        .we         (we_q),
        .d          (i_r_mem_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    // Request latch, sequencing FSM and all registered port drive.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            r_addr_q    <= '0;
            w_en_q      <= 1'b0;
            w_addr_q    <= '0;
            w_data_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        we_q     <= i_req_we;
                        funct3_q <= i_req_funct3;
                        addr_q   <= i_req_addr;
                        wdata_q  <= i_req_wdata;
                        if (i_req_we && !is_sub_word(i_req_funct3)) begin
                            // Whole-word store: write straight away.
                            state    <= WR;
                            w_en_q   <= 1'b1;
                            w_addr_q <= i_req_addr;
                            w_data_q <= i_req_wdata;
                        end else begin
                            // Read address is registered so it is on the
                            // port throughout RD_ADDR and then held.
                            state    <= RD_ADDR;
                            r_addr_q <= i_req_addr;
                        end
                    end
                end
                RD_ADDR: begin
                    state <= RD_DATA;
                end
                RD_DATA: begin
                    if (we_q) begin
                        state    <= WR;
                        w_en_q   <= 1'b1;
                        w_addr_q <= addr_q;
                        w_data_q <= store_data;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= load_data;
                    end
                end
                WR: begin
                    state       <= RESP;
                    w_en_q      <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= '0;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_req_ready     = (state == IDLE);
    assign o_rsp_valid     = rsp_valid_q;
    assign o_rsp_data      = rsp_data_q;
    assign o_r_mem_addr    = r_addr_q;
    assign o_w_mem_en[0]   = w_en_q;
    assign o_w_mem_addr[0] = w_addr_q;
    assign o_w_mem_data[0] = w_data_q;
    assign o_w_mem_en[1]   = 1'b0;
    assign o_w_mem_addr[1] = '0;
    assign o_w_mem_data[1] = '0;
    assign o_state         = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-array memory that wraps mod 256, a
// byte-level reference model, and a scoreboard fed at request acceptance.
module tb_load_store_unit;
    import Types::*;

    // ---------------- clock / reset ----------------
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_req_valid = 1'b0;
    logic       o_req_ready;
    logic       i_req_we = 1'b0;
    logic [2:0] i_req_funct3 = 3'd0;
    word        i_req_addr = '0;
    word        i_req_wdata = '0;
    logic       o_rsp_valid;
    logic       i_rsp_ready = 1'b1;
    word        o_rsp_data;
    word        o_r_mem_addr;
    word        i_r_mem_data;
    word        o_w_mem_addr [0:1];
    word        o_w_mem_data [0:1];
    logic       o_w_mem_en   [0:1];
    lsu_state_t o_state;

    always #5 i_clk = ~i_clk;

    load_store_unit dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_r_mem_addr (o_r_mem_addr),
        .i_r_mem_data (i_r_mem_data),
        .o_w_mem_addr (o_w_mem_addr),
        .o_w_mem_data (o_w_mem_data),
        .o_w_mem_en   (o_w_mem_en),
        .o_state      (o_state)
    );

    // ---------------- memory (the block the DUT talks to) ----------------
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];

    function automatic word mem_word(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
        return {mem[a], mem[a1], mem[a2], mem[a3]};
    endfunction

    function automatic word ref_word(input logic [7:0] a);
        logic [7:0] a1, a2, a3;
        a1 = a + 8'd1; a2 = a + 8'd2; a3 = a + 8'd3;
        return {ref_mem[a], ref_mem[a1], ref_mem[a2], ref_mem[a3]};
    endfunction

    always @(posedge i_clk) begin
        logic [7:0] wa;
        wa = o_w_mem_addr[0][7:0];
        i_r_mem_data <= mem_word(o_r_mem_addr[7:0]);
        if (o_w_mem_en[0]) begin
            mem[wa]        <= o_w_mem_data[0][31:24];
            mem[wa + 8'd1] <= o_w_mem_data[0][23:16];
            mem[wa + 8'd2] <= o_w_mem_data[0][15:8];
            mem[wa + 8'd3] <= o_w_mem_data[0][7:0];
        end
    end

    // ---------------- reference model ----------------
    function automatic word model_load(input word w, input logic [2:0] f3);
        case (f3)
            3'b000:  return w[31] ? (32'hFFFF_FF00 | (w >> 24)) : (w >> 24);
            3'b001:  return w[31] ? (32'hFFFF_0000 | (w >> 16)) : (w >> 16);
            3'b100:  return w >> 24;
            3'b101:  return w >> 16;
            default: return w;
        endcase
    endfunction

    task automatic model_store(input logic [7:0] a, input logic [2:0] f3, input word wd);
        case (f3)
            3'b000: ref_mem[a] = wd[7:0];
            3'b001: begin
                ref_mem[a]        = wd[15:8];
                ref_mem[a + 8'd1] = wd[7:0];
            end
            default: begin
                ref_mem[a]        = wd[31:24];
                ref_mem[a + 8'd1] = wd[23:16];
                ref_mem[a + 8'd2] = wd[15:8];
                ref_mem[a + 8'd3] = wd[7:0];
            end
        endcase
    endtask

    // ---------------- scoreboard state ----------------
    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  wen_cnt = 0;
    int  done_cnt = 0;
    int  rdy_mode = 0;      // 0: always ready, 1: random, 2: hold low
    word exp_q[$];
    int  lat_q[$];
    int  acc_q[$];
    int  wen_q[$];
    int  wbase_q[$];
    word wr_exp_addr = '0;
    word wr_exp_data = '0;
    logic rsp_seen = 1'b0;
    word  rsp_held = '0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic check(input string name, input word act, input word exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            rsp_seen = 1'b0;
        end else begin
            if (o_w_mem_en[0]) begin
                wen_cnt++;
                check("w_mem_addr", o_w_mem_addr[0], wr_exp_addr);
                check("w_mem_data", o_w_mem_data[0], wr_exp_data);
                check("no_write_in_resp", 32'(o_rsp_valid), 32'd0);
            end
            check("w_port1_idle", 32'(o_w_mem_en[1]) | o_w_mem_addr[1] | o_w_mem_data[1], 32'd0);
            if (o_rsp_valid) begin
                if (!rsp_seen) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_rsp", 32'd1, 32'd0);
                    end else begin
                        int acc, base;
                        acc  = acc_q.pop_front();
                        base = wbase_q.pop_front();
                        check("rsp_data", o_rsp_data, exp_q.pop_front());
                        check("rsp_latency", 32'(cyc - acc + 1), 32'(lat_q.pop_front()));
                        check("write_count", 32'(wen_cnt - base), 32'(wen_q.pop_front()));
                    end
                    rsp_seen = 1'b1;
                    rsp_held = o_rsp_data;
                end else begin
                    check("rsp_hold", o_rsp_data, rsp_held);
                    check("req_ready_stall", 32'(o_req_ready), 32'd0);
                end
                if (i_rsp_ready) begin
                    rsp_seen = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    // Response-ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            case (rdy_mode)
                0:       i_rsp_ready = 1'b1;
                1:       i_rsp_ready = 1'($urandom_range(0, 1));
                default: i_rsp_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        if (done_cnt < target) check("rsp_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input word addr,
                          input word wd, input logic wait_rsp);
        word exp_d;
        int  lat, wen, target;
        if (we) begin
            model_store(addr[7:0], f3, wd);
            exp_d       = '0;
            wen         = 1;
            lat         = (f3 == 3'b000 || f3 == 3'b001) ? 4 : 2;
            wr_exp_addr = addr;
            wr_exp_data = ref_word(addr[7:0]);
        end else begin
            exp_d = model_load(ref_word(addr[7:0]), f3);
            wen   = 0;
            lat   = 3;
        end
        wait_ready();
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wd;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        target = done_cnt + 1;
        exp_q.push_back(exp_d);
        lat_q.push_back(lat);
        acc_q.push_back(cyc);
        wen_q.push_back(wen);
        wbase_q.push_back(wen_cnt);
        if (wait_rsp) wait_done(target);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(o_req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(o_rsp_valid), 32'd0);
        check({tag, "_rsp_data"}, o_rsp_data, 32'd0);
        check({tag, "_r_mem_addr"}, o_r_mem_addr, 32'd0);
        check({tag, "_w_en"}, 32'(o_w_mem_en[0]), 32'd0);
        check({tag, "_w_addr"}, o_w_mem_addr[0], 32'd0);
        check({tag, "_w_data"}, o_w_mem_data[0], 32'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] init_a;
        int         base, target;

        for (int i = 0; i < 256; i++) begin
            init_a = 8'(i);
            mem[init_a] = 8'($urandom_range(0, 255));
            ref_mem[init_a] = mem[init_a];
        end
        for (int i = 0; i < 4; i++) begin
            init_a = 8'(8'h10 + i);
            mem[init_a] = 8'h00;
            ref_mem[init_a] = 8'h00;
        end
        mem[8'h20] = 8'h80; mem[8'h21] = 8'h7F; mem[8'h22] = 8'h01; mem[8'h23] = 8'h02;
        mem[8'h30] = 8'h11; mem[8'h31] = 8'h22; mem[8'h32] = 8'h33; mem[8'h33] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            init_a = 8'(8'h20 + i);
            ref_mem[init_a] = mem[init_a];
            init_a = 8'(8'h30 + i);
            ref_mem[init_a] = mem[init_a];
        end

        // Reset
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        check("reset_state", 32'(o_state), 32'(IDLE));
        i_rst_n = 1'b1;

        // SW then LW
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);

        // Loads with sign/zero extension
        do_req(1'b0, 3'b000, 32'h20, 32'h0, 1'b1);
        do_req(1'b0, 3'b100, 32'h20, 32'h0, 1'b1);
        do_req(1'b0, 3'b001, 32'h20, 32'h0, 1'b1);
        do_req(1'b0, 3'b101, 32'h20, 32'h0, 1'b1);
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 1'b1);

        // Read-modify-write
        do_req(1'b1, 3'b000, 32'h30, 32'h0000_00AB, 1'b1);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);
        do_req(1'b1, 3'b001, 32'h30, 32'h0000_CDEF, 1'b1);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, 1'b1);

        // Back-pressure on a load
        rdy_mode = 2;
        @(posedge i_clk);
        #2;
        target = done_cnt + 1;
        do_req(1'b0, 3'b001, 32'h20, 32'h0, 1'b0);
        begin
            int n;
            n = 0;
            while (!o_rsp_valid && n < 20) begin
                @(negedge i_clk);
                n++;
            end
        end
        repeat (5) @(negedge i_clk);
        check("bp_rsp_valid_held", 32'(o_rsp_valid), 32'd1);
        check("bp_req_ready_low", 32'(o_req_ready), 32'd0);
        rdy_mode = 0;
        wait_done(target);

        // Reset during RD_DATA of an SB
        base = wen_cnt;
        wait_ready();
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b000;
        i_req_addr   = 32'h30;
        i_req_wdata  = 32'h0000_0099;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check("abort_in_rd_data", 32'(o_state), 32'(RD_DATA));
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("abort_no_write", 32'(wen_cnt - base), 32'd0);
        check("abort_mem_intact", mem_word(8'h30), ref_word(8'h30));

        // Wrap-around at the top of the 256-byte memory
        do_req(1'b1, 3'b010, 32'hFD, 32'h0102_0304, 1'b1);
        do_req(1'b0, 3'b010, 32'hFD, 32'h0, 1'b1);
        do_req(1'b0, 3'b100, 32'h00, 32'h0, 1'b1);

        // Randomized traffic with random response back-pressure
        rdy_mode = 1;
        for (int i = 0; i < 80; i++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                   $urandom, 1'b1);
        end
        rdy_mode = 0;
        repeat (3) @(negedge i_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 256; i++) begin
            init_a = 8'(i);
            if (mem[init_a] !== ref_mem[init_a])
                check("final_mem_byte", {24'd0, mem[init_a]}, {24'd0, ref_mem[init_a]});
        end
        check("final_mem_word", mem_word(8'h10), ref_word(8'h10));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound on the whole run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
